// File: rtl/mem_stage_unit.sv
// mem_stage_unit -- MEM-stage access unit of the five-stage MIPS pipeline.
//
// Takes the EX/MEM register outputs and either forwards the ALU result to
// MEM/WB (one cycle of latency) or runs a load/store against data memory
// over a req/ack handshake. The pipeline is stalled while the access is
// outstanding. An access that gets no ack within TIMEOUT cycles is aborted.
//
// Ports
//   clock, reset            pipeline clock; asynchronous active-high reset
//   MEM_D1/MEM_D2/MEM_RD    ALU result (address), store data, dest register
//   mem_read/mem_write      load / store instruction
//   mem_byte/mem_unsigned   byte access; zero-extend byte load (LBU)
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be          registered data-memory request
//   dm_rdata/dm_ack         memory read data and one-cycle completion pulse
//   stall                   combinational hold for upstream stages
//   WB_D/WB_RD              MEM/WB result; WB_RD=0 means no writeback
//   mem_err                 one-cycle pulse on illegal op or timeout
//
// state  | meaning
// IDLE   | evaluating the EX/MEM instruction each cycle
// ACCESS | request outstanding, waiting for dm_ack or timeout

module mem_stage_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] MEM_D1,
  input  logic [31:0] MEM_D2,
  input  logic [4:0]  MEM_RD,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_unsigned,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic [31:0] WB_D,
  output logic [4:0]  WB_RD,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Last counter value allowed before the access is aborted.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] count;
  logic [4:0]  rd_q;
  logic        byte_q;
  logic        uns_q;
  logic        read_q;
  logic [1:0]  lane_q;

  logic mem_op;
  logic illegal;
  logic timeout_hit;

  assign mem_op      = mem_read | mem_write;
  assign illegal     = (mem_read & mem_write) |
                       (mem_op & ~mem_byte & (|MEM_D1[1:0]));
  assign timeout_hit = (count == LAST_CNT);

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = mem_op & ~illegal;
      ACCESS:  stall = ~dm_ack & ~timeout_hit;
      default: stall = 1'b0;
    endcase
  end

  function automatic logic [31:0] load_data(input logic [31:0] rdata,
                                            input logic        is_byte,
                                            input logic        is_uns,
                                            input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    shifted = rdata >> {lane, 3'b000};
    b       = shifted[7:0];
    if (!is_byte)
      load_data = rdata;
    else if (is_uns)
      load_data = {24'h0, b};
    else
      load_data = {{24{b[7]}}, b};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      rd_q     <= '0;
      byte_q   <= 1'b0;
      uns_q    <= 1'b0;
      read_q   <= 1'b0;
      lane_q   <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_be    <= '0;
      WB_D     <= '0;
      WB_RD    <= '0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            WB_D  <= MEM_D1;
            WB_RD <= MEM_RD;
          end else if (illegal) begin
            WB_D    <= '0;
            WB_RD   <= '0;
            mem_err <= 1'b1;
          end else begin
            rd_q    <= MEM_RD;
            byte_q  <= mem_byte;
            uns_q   <= mem_unsigned;
            read_q  <= mem_read;
            lane_q  <= MEM_D1[1:0];
            count   <= '0;
            dm_req  <= 1'b1;
            dm_we   <= mem_write;
            dm_addr <= {MEM_D1[31:2], 2'b00};
            if (mem_write && mem_byte) begin
              dm_be    <= 4'b0001 << MEM_D1[1:0];
              dm_wdata <= {4{MEM_D2[7:0]}};
            end else if (mem_write) begin
              dm_be    <= 4'hF;
              dm_wdata <= MEM_D2;
            end else begin
              dm_be    <= 4'hF;
              dm_wdata <= '0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // ack wins over a timeout landing in the same cycle
          if (dm_ack) begin
            dm_req <= 1'b0;
            state  <= IDLE;
            if (read_q) begin
              WB_D  <= load_data(dm_rdata, byte_q, uns_q, lane_q);
              WB_RD <= rd_q;
            end else begin
              WB_D  <= '0;
              WB_RD <= '0;
            end
          end else if (timeout_hit) begin
            dm_req  <= 1'b0;
            state   <= IDLE;
            WB_D    <= '0;
            WB_RD   <= '0;
            mem_err <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

MEM-stage access unit of the five-stage MIPS pipeline: consumes the EX/MEM pipeline-register outputs (ALU result/address, store data, destination register), performs the load/store against the data memory through a req/ack handshake, stalls the pipeline while the access is outstanding, and registers the MEM/WB result. Non-memory instructions pass through with one cycle of latency.

## Interface
- TIMEOUT, 255: max cycles in ACCESS waiting for dm_ack before abort (1..65535)
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- MEM_D1  in  32  ALU result; effective address for loads/stores
- MEM_D2  in  32  store data
- MEM_RD  in  5  destination register
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- mem_byte  in  1  1 = byte access, 0 = word access
- mem_unsigned  in  1  1 = zero-extend byte load (LBU), 0 = sign-extend (LB)
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = write
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dm_wdata  out  32  write data
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  one-cycle completion pulse
- stall  out  1  hold upstream stages and MEM-stage inputs
- WB_D  out  32  writeback data
- WB_RD  out  5  writeback register; 0 = no writeback
- mem_err  out  1  one-cycle error pulse

## Operation
- States: IDLE, ACCESS.
- IDLE, no memory op (mem_read=mem_write=0): next edge WB_D<=MEM_D1, WB_RD<=MEM_RD; stall=0.
- IDLE, illegal op: mem_read=mem_write=1, or word access with MEM_D1[1:0]!=0 -> no request; next edge WB_RD<=0, WB_D<=0, mem_err=1 for one cycle; stall=0.
- IDLE, legal op: stall=1 combinationally; next edge latch address, data, RD, byte/unsigned/read flags; dm_req<=1, dm_we<=mem_write; state->ACCESS; timeout counter<=0.
- Store lanes: word -> dm_be=4'hF, dm_wdata=MEM_D2; byte -> dm_be=1<<addr[1:0], dm_wdata={4{MEM_D2[7:0]}}. Loads: dm_be=4'hF, dm_wdata=0.
- ACCESS: dm_req held 1, all dm_* outputs stable. stall = !dm_ack && counter!=TIMEOUT-1.
- ACCESS, dm_ack=1: at that edge dm_req<=0, state->IDLE. Load: WB_RD<=latched RD, WB_D<=dm_rdata (word) or selected byte lane rdata[8*a+7:8*a] zero/sign-extended per mem_unsigned. Store: WB_RD<=0, WB_D<=0.
- ACCESS, no ack: counter increments; when counter==TIMEOUT-1 without ack -> abort: dm_req<=0, state->IDLE, WB_RD<=0, mem_err pulse, stall=0 that cycle.
- dm_ack in IDLE is ignored.
- Upstream holds MEM_* inputs stable while stall=1; unit uses latched copies only.

## Timing
- Reset (async): state IDLE, counter 0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0, WB_D=0, WB_RD=0, mem_err=0; stall=0. Reset during ACCESS drops dm_req immediately; pending access discarded.
- Pass-through latency: 1 cycle.
- Memory op: issue edge + N ACCESS cycles; ack in first ACCESS cycle -> result on WB 2 edges after instruction arrives, stall high for exactly 2 cycles.
- Back-to-back memory ops: next op evaluated in IDLE the cycle after ack; dm_req low for at least 1 cycle between accesses.
- stall is combinational from state, inputs, dm_ack, counter; all other outputs registered.

## Test plan
- Pass-through: MEM_D1=0x1234_5678, MEM_RD=9, no mem op -> next edge WB_D=0x12345678, WB_RD=9, stall=0, dm_req never 1.
- Word load: addr 0x100, RD=4, dm_ack 3 cycles after dm_req rises with dm_rdata=0xDEADBEEF -> dm_addr=0x100, stall high 4 cycles, WB_D=0xDEADBEEF, WB_RD=4.
- Byte loads: addr 0x203, rdata 0x80AA_BBCC -> LB WB_D=0xFFFFFF80; LBU WB_D=0x00000080.
- Byte store: addr 0x301, MEM_D2=0x0000_005A -> dm_we=1, dm_addr=0x300, dm_be=4'b0010, dm_wdata=0x5A5A5A5A; after ack WB_RD=0.
- Errors: word load at 0x102 -> mem_err pulse, no dm_req, WB_RD=0; TIMEOUT=4 with no ack -> dm_req drops after 4 ACCESS cycles, mem_err pulse, stall=0.
- Reset mid-ACCESS: assert reset while dm_req=1 -> dm_req=0 immediately, later ack ignored, WB_RD=0.
